// File: rtl/ann_seq_classifier.sv
// Sequential ANN classifier: one time-multiplexed MAC scores N_OUT neurons from external memory and tracks the argmax.
// Optional feature: define ANN_RELU_EN to clamp negative scores to zero before the compare.
module ann_seq_classifier #(
    parameter int N_IN   = 64,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     rd_en,
    output logic [$clog2(N_IN)-1:0]  in_idx,
    output logic [$clog2(N_OUT)-1:0] out_idx,
    input  logic [DATA_W-1:0]        img_data,
    input  logic [DATA_W-1:0]        wt_data,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_OUT)-1:0] class_id,
    output logic [DATA_W-1:0]        max_score,
    output logic [7:0]               seven_seg
);

    localparam int IN_W  = $clog2(N_IN);
    localparam int OUT_W = $clog2(N_OUT);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [IN_W-1:0]  LAST_IN  = IN_W'(N_IN - 1);
    localparam logic [OUT_W-1:0] LAST_OUT = OUT_W'(N_OUT - 1);

    localparam logic signed [ACC_W-1:0] SC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef ANN_RELU_EN
    localparam logic signed [DATA_W-1:0] BEST_INIT = '0;
`else
    localparam logic signed [DATA_W-1:0] BEST_INIT = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_CMP,
        S_FIN
    } state_t;

    state_t                    state;
    logic                      vld;
    logic signed [ACC_W-1:0]   acc;
    logic signed [DATA_W-1:0]  best_score;
    logic [OUT_W-1:0]          best_idx;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   sh;
    logic signed [DATA_W-1:0]  score;

    function automatic logic [7:0] seg_code(input logic [OUT_W-1:0] idx);
        logic [3:0] v;
        v = 4'(idx);
        case (v)
            4'h0: seg_code = 8'h3F;
            4'h1: seg_code = 8'h06;
            4'h2: seg_code = 8'h5B;
            4'h3: seg_code = 8'h4F;
            4'h4: seg_code = 8'h66;
            4'h5: seg_code = 8'h6D;
            4'h6: seg_code = 8'h7D;
            4'h7: seg_code = 8'h07;
            4'h8: seg_code = 8'h7F;
            4'h9: seg_code = 8'h6F;
            4'hA: seg_code = 8'h77;
            4'hB: seg_code = 8'h7C;
            4'hC: seg_code = 8'h39;
            4'hD: seg_code = 8'h5E;
            4'hE: seg_code = 8'h79;
            default: seg_code = 8'h71;
        endcase
    endfunction

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        prod = $signed(img_data) * $signed(wt_data);
        sh   = acc >>> FRAC_W;
        if (sh > SC_MAX)
            score = SC_MAX[DATA_W-1:0];
        else if (sh < SC_MIN)
            score = SC_MIN[DATA_W-1:0];
        else
            score = sh[DATA_W-1:0];
`ifdef ANN_RELU_EN
        if (score[DATA_W-1])
            score = '0;
`endif
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            rd_en      <= 1'b0;
            in_idx     <= '0;
            out_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_id   <= '0;
            max_score  <= '0;
            seven_seg  <= 8'h00;
            vld        <= 1'b0;
            acc        <= '0;
            best_score <= '0;
            best_idx   <= '0;
        end else begin
            done <= 1'b0;
            // Memory data lags the read strobe by one cycle.
            vld  <= rd_en;
            if (vld)
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                rd_en <= 1'b0;
                busy  <= 1'b0;
                vld   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state      <= S_FETCH;
                            rd_en      <= 1'b1;
                            busy       <= 1'b1;
                            in_idx     <= '0;
                            out_idx    <= '0;
                            acc        <= '0;
                            best_score <= BEST_INIT;
                            best_idx   <= '0;
                        end
                    end
                    S_FETCH: begin
                        if (in_idx == LAST_IN) begin
                            rd_en <= 1'b0;
                            state <= S_DRAIN;
                        end else begin
                            in_idx <= in_idx + IN_W'(1);
                        end
                    end
                    S_DRAIN: state <= S_CMP;
                    S_CMP: begin
                        // Strict compare: ties keep the lowest neuron index.
                        if (score > best_score) begin
                            best_score <= score;
                            best_idx   <= out_idx;
                        end
                        acc <= '0;
                        if (out_idx == LAST_OUT) begin
                            state <= S_FIN;
                        end else begin
                            out_idx <= out_idx + OUT_W'(1);
                            in_idx  <= '0;
                            rd_en   <= 1'b1;
                            state   <= S_FETCH;
                        end
                    end
                    S_FIN: begin
                        class_id  <= best_idx;
                        max_score <= best_score;
                        seven_seg <= seg_code(best_idx);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
